// File: rtl/p2s_tx_scheduler_if.sv
// Requester-side bus of the shared serializer scheduler.
// Handshake: req is a level valid held with its word until ack pulses for one
// cycle; the word may change (or req drop) right after ack, never before it.
interface p2s_tx_scheduler_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_last;
  logic [32*N_REQ-1:0] req_bits;
  logic [5*N_REQ-1:0] req_width;
  logic [N_REQ-1:0]   ack;

  modport master (output req, req_last, req_bits, req_width, input ack);
  modport slave  (input req, req_last, req_bits, req_width, output ack);
endinterface

// File: rtl/p2s_tx_scheduler.sv
// Round-robin packet scheduler feeding one parallel-to-serial converter; the
// next word is loaded on the edge the converter samples the last bit.
module p2s_tx_scheduler #(
  parameter int N_REQ = 4
) (
  input  logic               clock,
  input  logic               reset,
  p2s_tx_scheduler_if.slave  rq,
  output logic               ser_reset_n,
  output logic [4:0]         ser_width,
  output logic [31:0]        ser_bits,
  input  logic               ser_need_load,
  output logic               busy,
  output logic [2:0]         owner,
  output logic               underrun,
  output logic               sync_err,
  output logic [1:0]         state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state, state_nx;
  logic [4:0]       cnt;
  logic             lock, exp_nl, first_run;
  logic [2:0]       rr, sel, rr_nx;
  logic             have_cand, capture, to_drain, load_pt, sel_last;
  logic [N_REQ-1:0] elig, sel_hot;
  logic [31:0]      sel_bits;
  logic [4:0]       sel_width;

  // A requester acked last cycle still shows its old word, so it sits out.
  assign elig      = rq.req & ~rq.ack;
  assign load_pt   = (state == RUN) && (cnt == ser_width - 5'd1);
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign rr_nx     = (sel == 3'(N_REQ - 1)) ? 3'd0 : sel + 3'd1;

  always_comb begin
    have_cand = 1'b0;
    sel       = '0;
    if (lock) begin
      for (int i = 0; i < N_REQ; i++)
        if (owner == 3'(i) && elig[i]) begin
          have_cand = 1'b1;
          sel       = 3'(i);
        end
    end else begin
      // Wrapped candidates first, then those at/above rr override them.
      for (int i = N_REQ - 1; i >= 0; i--)
        if (elig[i] && 3'(i) < rr) begin
          have_cand = 1'b1;
          sel       = 3'(i);
        end
      for (int i = N_REQ - 1; i >= 0; i--)
        if (elig[i] && 3'(i) >= rr) begin
          have_cand = 1'b1;
          sel       = 3'(i);
        end
    end
  end

  always_comb begin
    sel_bits  = '0;
    sel_width = '0;
    sel_last  = 1'b0;
    sel_hot   = '0;
    for (int i = 0; i < N_REQ; i++)
      if (sel == 3'(i)) begin
        sel_bits   = rq.req_bits[32*i +: 32];
        sel_width  = rq.req_width[5*i +: 5];
        sel_last   = rq.req_last[i];
        sel_hot[i] = 1'b1;
      end
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    to_drain = 1'b0;
    case (state)
      IDLE: if (have_cand) begin
        capture  = 1'b1;
        state_nx = RUN;
      end
      RUN: if (load_pt) begin
        if (have_cand) capture = 1'b1;
        else begin
          to_drain = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rq.ack      <= '0;
      ser_reset_n <= 1'b0;
      ser_width   <= '0;
      ser_bits    <= '0;
      owner       <= '0;
      underrun    <= 1'b0;
      sync_err    <= 1'b0;
      lock        <= 1'b0;
      rr          <= '0;
      cnt         <= '0;
      exp_nl      <= 1'b0;
      first_run   <= 1'b0;
    end else begin
      rq.ack      <= capture ? sel_hot : '0;
      ser_reset_n <= (state_nx != IDLE);
      exp_nl      <= load_pt && have_cand;
      first_run   <= (state == IDLE) && capture;
      if (state == RUN && !first_run && (ser_need_load != exp_nl)) sync_err <= 1'b1;
      if (to_drain && lock) underrun <= 1'b1;
      if (capture) begin
        ser_bits  <= sel_bits;
        ser_width <= sel_width;
        cnt       <= '0;
        owner     <= sel;
        lock      <= ~sel_last;
        if (sel_last) rr <= rr_nx;
      end else begin
        if (state == RUN) cnt <= cnt + 5'd1;
        // Width 0 during DRAIN keeps the converter busy on one zero sample.
        if (to_drain) begin
          ser_bits  <= '0;
          ser_width <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_p2s_tx_scheduler.sv
// Directed bench: converter model, serial-bit scoreboard, arbitration,
// underrun, sync-check and asynchronous-reset scenarios.
module tb_p2s_tx_scheduler;
  logic        clock, reset;
  logic        ser_reset_n, ser_need_load, busy, underrun, sync_err;
  logic [4:0]  ser_width;
  logic [31:0] ser_bits;
  logic [2:0]  owner;
  logic [1:0]  state_dbg;

  p2s_tx_scheduler_if #(.N_REQ(4)) bus ();

  p2s_tx_scheduler #(.N_REQ(4)) dut (
    .clock(clock), .reset(reset), .rq(bus),
    .ser_reset_n(ser_reset_n), .ser_width(ser_width), .ser_bits(ser_bits),
    .ser_need_load(ser_need_load), .busy(busy), .owner(owner),
    .underrun(underrun), .sync_err(sync_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // converter model: samples one bit per edge while running
  logic [4:0] ccnt;
  logic       nl_m, nl_kill, smp_valid, smp_bit;
  assign ser_need_load = nl_m & ~nl_kill;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ccnt <= '0; nl_m <= 1'b0; smp_valid <= 1'b0; smp_bit <= 1'b0;
    end else if (!ser_reset_n) begin
      ccnt <= '0; nl_m <= 1'b0; smp_valid <= 1'b0;
    end else begin
      smp_valid <= 1'b1;
      smp_bit   <= ser_bits[ccnt];
      if (ccnt == ser_width - 5'd1) begin
        ccnt <= '0; nl_m <= 1'b1;
      end else begin
        ccnt <= ccnt + 5'd1; nl_m <= 1'b0;
      end
    end
  end

  // scoreboard state
  logic [0:0] exp_q[$];
  int n_checks = 0, n_fail = 0, sb_extra = 0, cyc = 0, busy_cnt = 0;
  int ack_cnt[4];
  bit sb_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (smp_valid && sb_en) begin
      if (exp_q.size() == 0) sb_extra++;
      else check("serial_bit", 32'(smp_bit), 32'(exp_q.pop_front()));
    end
    for (int i = 0; i < 4; i++) if (bus.ack[i]) ack_cnt[i]++;
    if (busy) busy_cnt++;
  endtask

  // driver tasks
  task automatic put(input int idx, input logic [31:0] bits, input logic [4:0] w, input logic last);
    bus.req[idx]               = 1'b1;
    bus.req_last[idx]          = last;
    bus.req_bits[32*idx +: 32] = bits;
    bus.req_width[5*idx +: 5]  = w;
  endtask

  task automatic drop(input int idx);
    bus.req[idx] = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] bits, input logic [4:0] w);
    int weff;
    weff = (w == 5'd0) ? 32 : int'(w);
    for (int i = 0; i < 32; i++) if (i < weff) exp_q.push_back(bits[i]);
  endtask

  task automatic push_drain();
    exp_q.push_back(1'b0);
  endtask

  task automatic wait_ack(input int idx, output int t);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack == 4'd0 && n < 200);
    check($sformatf("ack_%0d", idx), 32'(bus.ack), 32'(1 << idx));
    t = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    check({tag, "_serial_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  int t1, t2, t3, a0, b0, hi, n;

  initial begin
    bus.req = '0; bus.req_last = '0; bus.req_bits = '0; bus.req_width = '0;
    nl_kill = 1'b0;
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    reset = 1'b1;
    #12;
    do_reset();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_ser_reset_n", 32'(ser_reset_n), 32'd0);
    check("rst_ser_width", 32'(ser_width), 32'd0);
    check("rst_ser_bits", ser_bits, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_flags", {30'd0, underrun, sync_err}, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // single 8-bit word from req0
    push_word(32'h0000_00A5, 5'd8); push_drain();
    a0 = ack_cnt[0];
    put(0, 32'h0000_00A5, 5'd8, 1'b1);
    wait_ack(0, t1);
    drop(0);
    hi = 0; n = 0;
    while (ser_reset_n && n < 100) begin
      hi++;
      tick();
      n++;
    end
    check("single_run_cycles", 32'(hi), 32'd9);
    wait_idle("single_idle");
    check("single_ack_pulses", 32'(ack_cnt[0] - a0), 32'd1);

    // back-to-back three-word packet from req1
    push_word(32'h5, 5'd4); push_word(32'hC, 5'd4); push_word(32'hDEAD_BEEF, 5'd0); push_drain();
    b0 = busy_cnt;
    put(1, 32'h5, 5'd4, 1'b0);
    wait_ack(1, t1);
    put(1, 32'hC, 5'd4, 1'b0);
    wait_ack(1, t2);
    put(1, 32'hDEAD_BEEF, 5'd0, 1'b1);
    wait_ack(1, t3);
    drop(1);
    wait_idle("b2b_idle");
    check("b2b_ack_gap1", 32'(t2 - t1), 32'd4);
    check("b2b_ack_gap2", 32'(t3 - t2), 32'd4);
    check("b2b_busy_cycles", 32'(busy_cnt - b0), 32'd41);
    check("b2b_owner", 32'(owner), 32'd1);

    // round robin between req0 and req2 from rr=0
    do_reset();
    push_word(32'h9, 5'd4); push_word(32'h6, 5'd4); push_word(32'h9, 5'd4); push_word(32'h6, 5'd4); push_drain();
    put(0, 32'h9, 5'd4, 1'b1);
    put(2, 32'h6, 5'd4, 1'b1);
    wait_ack(0, t1);
    wait_ack(2, t1);
    wait_ack(0, t1);
    wait_ack(2, t1);
    drop(0); drop(2);
    wait_idle("rr_idle");

    // locked packet from req2 is not interleaved with req0
    push_word(32'h3, 5'd4); push_word(32'hA, 5'd4); push_word(32'h5, 5'd4); push_word(32'hF, 5'd4); push_drain();
    put(2, 32'h3, 5'd4, 1'b0);
    wait_ack(2, t1);
    put(0, 32'hF, 5'd4, 1'b1);
    put(2, 32'hA, 5'd4, 1'b0);
    wait_ack(2, t1);
    put(2, 32'h5, 5'd4, 1'b1);
    wait_ack(2, t1);
    drop(2);
    wait_ack(0, t1);
    drop(0);
    wait_idle("lock_idle");
    check("lock_owner", 32'(owner), 32'd0);

    // underrun: req3 abandons its packet mid-way
    push_word(32'h2D, 5'd6); push_drain();
    put(3, 32'h2D, 5'd6, 1'b0);
    wait_ack(3, t1);
    drop(3);
    wait_idle("underrun_idle");
    check("underrun_set", 32'(underrun), 32'd1);
    check("underrun_owner", 32'(owner), 32'd3);
    put(0, 32'h7, 5'd4, 1'b1);
    a0 = ack_cnt[0];
    repeat (8) tick();
    check("locked_out_ack0", 32'(ack_cnt[0] - a0), 32'd0);
    check("locked_out_busy", 32'(busy), 32'd0);
    push_word(32'h12, 5'd6); push_word(32'h7, 5'd4); push_drain();
    put(3, 32'h12, 5'd6, 1'b1);
    wait_ack(3, t1);
    drop(3);
    wait_ack(0, t1);
    drop(0);
    wait_idle("resume_idle");
    check("underrun_sticky", 32'(underrun), 32'd1);
    check("sync_clean", 32'(sync_err), 32'd0);

    // suppressed need_load pulse
    nl_kill = 1'b1;
    push_word(32'hF, 5'd4); push_word(32'h3, 5'd4); push_drain();
    put(1, 32'hF, 5'd4, 1'b0);
    wait_ack(1, t1);
    put(1, 32'h3, 5'd4, 1'b1);
    wait_ack(1, t1);
    drop(1);
    wait_idle("sync_idle");
    nl_kill = 1'b0;
    check("sync_err_set", 32'(sync_err), 32'd1);
    repeat (5) tick();
    check("sync_err_sticky", 32'(sync_err), 32'd1);

    // asynchronous reset in the middle of a 16-bit word
    sb_en = 1'b0;
    put(2, 32'h0000_BEEF, 5'd16, 1'b1);
    wait_ack(2, t1);
    drop(2);
    repeat (5) tick();
    check("mid_word_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_ser_reset_n", 32'(ser_reset_n), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ser_bits", ser_bits, 32'd0);
    check("arst_ser_width", 32'(ser_width), 32'd0);
    check("arst_owner", 32'(owner), 32'd0);
    check("arst_flags", {30'd0, underrun, sync_err}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    sb_en = 1'b1;
    push_word(32'h1, 5'd3); push_word(32'h6, 5'd3); push_drain();
    put(1, 32'h1, 5'd3, 1'b1);
    put(3, 32'h6, 5'd3, 1'b1);
    wait_ack(1, t1);
    drop(1);
    wait_ack(3, t2);
    drop(3);
    wait_idle("post_reset_idle");
    check("post_reset_gap", 32'(t2 - t1), 32'd3);
    check("serial_extra", 32'(sb_extra), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
